// File: rtl/ledpanel_scan.sv
// rtl/ledpanel_scan.sv - HUB75 1/8-scan panel driver with 8-plane binary-coded modulation
// Reads pixels from the double-buffered frame buffer and owns its display-select bit.
module ledpanel_scan #(
    parameter int BASE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       swap_req,
    output logic       display,
    output logic       swap_done,
    output logic [2:0] row,
    output logic [5:0] col,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic       panel_r,
    output logic       panel_g,
    output logic       panel_b,
    output logic       panel_clk,
    output logic       panel_lat,
    output logic       panel_oe_n,
    output logic [2:0] panel_a
);

    localparam int SHOW_MAX = BASE << 7;
    localparam int SW       = $clog2(SHOW_MAX + 1);

    typedef enum logic [1:0] {
        ST_SHIFT,
        ST_TRAIL,
        ST_LATCH,
        ST_SHOW
    } state_t;

    state_t        r_state;
    logic [2:0]    r_scan;
    logic [2:0]    r_row;
    logic [2:0]    r_plane;
    logic [5:0]    r_col;
    logic          r_ph;
    logic [SW-1:0] r_show;
    logic          r_display;
    logic          r_swap_done;
    logic          r_swap_pending;
    logic          r_panel_r;
    logic          r_panel_g;
    logic          r_panel_b;
    logic          r_panel_clk;
    logic          r_panel_lat;
    logic          r_panel_oe_n;
    logic [2:0]    r_panel_a;

    logic [SW-1:0] w_show_last;
    logic          w_frame_end;

    assign w_show_last = (SW'(BASE) << r_plane) - SW'(1);
    assign w_frame_end = (r_state == ST_SHOW) && (r_show == '0) &&
                         (r_plane == 3'd7) && (r_scan == 3'd7);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_SHIFT;
            r_scan         <= 3'd0;
            r_row          <= 3'd7;
            r_plane        <= 3'd0;
            r_col          <= 6'd0;
            r_ph           <= 1'b0;
            r_show         <= '0;
            r_display      <= 1'b0;
            r_swap_done    <= 1'b0;
            r_swap_pending <= 1'b0;
            r_panel_r      <= 1'b0;
            r_panel_g      <= 1'b0;
            r_panel_b      <= 1'b0;
            r_panel_clk    <= 1'b0;
            r_panel_lat    <= 1'b0;
            r_panel_oe_n   <= 1'b1;
            r_panel_a      <= 3'd0;
        end else begin
            // A request landing on the frame-end cycle survives into the next frame.
            if (w_frame_end && r_swap_pending) begin
                r_display      <= ~r_display;
                r_swap_done    <= 1'b1;
                r_swap_pending <= swap_req;
            end else begin
                r_swap_done    <= 1'b0;
                r_swap_pending <= r_swap_pending | swap_req;
            end

            case (r_state)
                ST_SHIFT: begin
                    r_panel_oe_n <= 1'b1;
                    r_panel_lat  <= 1'b0;
                    if (!r_ph) begin
                        // Pixel 0 has no predecessor to clock out.
                        r_panel_clk <= (r_col != 6'd0);
                        r_ph        <= 1'b1;
                    end else begin
                        r_panel_r   <= red[r_plane];
                        r_panel_g   <= green[r_plane];
                        r_panel_b   <= blue[r_plane];
                        r_panel_clk <= 1'b0;
                        r_ph        <= 1'b0;
                        if (r_col == 6'd63) begin
                            r_state <= ST_TRAIL;
                        end else begin
                            r_col <= r_col + 6'd1;
                        end
                    end
                end

                ST_TRAIL: begin
                    r_panel_clk <= 1'b1;
                    r_state     <= ST_LATCH;
                end

                ST_LATCH: begin
                    r_panel_clk  <= 1'b0;
                    r_panel_lat  <= 1'b1;
                    r_panel_oe_n <= 1'b1;
                    r_panel_a    <= r_scan;
                    r_show       <= w_show_last;
                    r_state      <= ST_SHOW;
                end

                ST_SHOW: begin
                    r_panel_lat  <= 1'b0;
                    r_panel_oe_n <= 1'b0;
                    if (r_show == '0) begin
                        r_col   <= 6'd0;
                        r_state <= ST_SHIFT;
                        if (r_plane != 3'd7) begin
                            r_plane <= r_plane + 3'd1;
                        end else begin
                            r_plane <= 3'd0;
                            r_scan  <= r_scan + 3'd1;
                            // The buffer adds one to row, so row trails scan by one.
                            r_row   <= r_scan;
                        end
                    end else begin
                        r_show <= r_show - SW'(1);
                    end
                end

                default: r_state <= ST_SHIFT;
            endcase
        end
    end

    assign display    = r_display;
    assign swap_done  = r_swap_done;
    assign row        = r_row;
    assign col        = r_col;
    assign panel_r    = r_panel_r;
    assign panel_g    = r_panel_g;
    assign panel_b    = r_panel_b;
    assign panel_clk  = r_panel_clk;
    assign panel_lat  = r_panel_lat;
    assign panel_oe_n = r_panel_oe_n;
    assign panel_a    = r_panel_a;

endmodule

// File: tb/tb_ledpanel_scan.sv
// tb/tb_ledpanel_scan.sv - scoreboard bench for ledpanel_scan (BASE=4 main, BASE=1 blanking)
module tb_ledpanel_scan;

    localparam int B4 = 4;
    localparam int B1 = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst1 = 1'b1;
    logic swap_req = 1'b0;

    logic       display, swap_done;
    logic [2:0] row, pa;
    logic [5:0] col;
    logic [7:0] red, green, blue;
    logic       pr, pg, pb, pclk, plat, poe;

    logic       d1_display, d1_swap_done;
    logic [2:0] d1_row, d1_pa;
    logic [5:0] d1_col;
    logic [7:0] d1_red, d1_green, d1_blue;
    logic       d1_pr, d1_pg, d1_pb, d1_pclk, d1_lat, d1_oe;

    logic [23:0] mem [512];

    logic [2:0] q_bits [$];
    int         q_a [$];
    int         q_w [$];
    int         q_sw [$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = -1;
    int cyc1 = -1;
    int line_len = 0;
    int frame_len = 0;
    int last_t = -1;

    ledpanel_scan #(.BASE(B4)) dut4 (
        .clk(clk), .reset(reset), .swap_req(swap_req),
        .display(display), .swap_done(swap_done),
        .row(row), .col(col), .red(red), .green(green), .blue(blue),
        .panel_r(pr), .panel_g(pg), .panel_b(pb),
        .panel_clk(pclk), .panel_lat(plat), .panel_oe_n(poe), .panel_a(pa)
    );

    ledpanel_scan #(.BASE(B1)) dut1 (
        .clk(clk), .reset(rst1), .swap_req(1'b0),
        .display(d1_display), .swap_done(d1_swap_done),
        .row(d1_row), .col(d1_col), .red(d1_red), .green(d1_green), .blue(d1_blue),
        .panel_r(d1_pr), .panel_g(d1_pg), .panel_b(d1_pb),
        .panel_clk(d1_pclk), .panel_lat(d1_lat), .panel_oe_n(d1_oe), .panel_a(d1_pa)
    );

    always #5 clk = ~clk;

    // Synchronous frame buffer: fetches scanline row+1, column halves swapped in the address.
    logic [2:0] rs4, rs1;
    logic [8:0] ra4, ra1;
    assign rs4 = row + 3'd1;
    assign rs1 = d1_row + 3'd1;
    assign ra4 = {~col[5], rs4, col[4:0]};
    assign ra1 = {~d1_col[5], rs1, d1_col[4:0]};
    always @(posedge clk) {red, green, blue} <= mem[ra4];
    always @(posedge clk) {d1_red, d1_green, d1_blue} <= mem[ra1];

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= -1;
        else       cyc <= cyc + 1;
    end

    always @(posedge clk or posedge rst1) begin
        if (rst1) cyc1 <= -1;
        else      cyc1 <= cyc1 + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic inv(input string nm, input logic oe, input logic lat, input logic ck,
                       input logic pck, input logic [2:0] a, input logic [2:0] preva);
        n_chk++;
        if (!oe && (lat || ck != pck || a != preva)) begin
            n_fail++;
            $display("FAIL %s blanking: oe_n=%0b lat=%0b clk %0b->%0b panel_a %0d->%0d",
                     nm, oe, lat, pck, ck, preva, a);
        end
    endtask

    // Expected panel stream from plane 0 of scanline 0 onwards.
    task automatic push_planes(input int n);
        logic [8:0]  a;
        logic [5:0]  k6;
        logic [2:0]  s3, p3;
        logic [23:0] w;
        for (int i = 0; i < n; i++) begin
            p3 = 3'(i % 8);
            s3 = 3'((i / 8) % 8);
            for (int k = 0; k < 64; k++) begin
                k6 = 6'(k);
                a  = {~k6[5], s3, k6[4:0]};
                w  = mem[a];
                q_bits.push_back({w[16 + p3], w[8 + p3], w[p3]});
            end
            q_a.push_back(int'(s3));
            q_w.push_back(B4 << p3);
        end
    endtask

    task automatic pulse_swap(input int c, input bit counts);
        int t;
        while (cyc < c - 1) @(negedge clk);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        if (counts) begin
            if (c % frame_len == frame_len - 1) t = c + frame_len;
            else                                t = (c / frame_len + 1) * frame_len - 1;
            if (t != last_t) begin
                q_sw.push_back(t);
                last_t = t;
            end
        end
    endtask

    logic       pclk_q, poe_q, disp_q, seen_rise;
    logic [2:0] pa_q, exp_b;
    int         edges, low, lat_cyc, line_cyc, nlat, cur_w, cur_scan;

    always @(negedge clk) begin
        if (reset) begin
            pclk_q = 1'b0; poe_q = 1'b1; pa_q = 3'd0; disp_q = 1'b0; seen_rise = 1'b0;
            edges = 0; low = 0; lat_cyc = -1; line_cyc = -1; nlat = 0; cur_w = 0; cur_scan = 0;
        end else begin
            inv("dut4", poe, plat, pclk, pclk_q, pa, pa_q);
            if (pclk && !pclk_q) begin
                if (!seen_rise) begin
                    chk("first_rise_cycle", cyc, 2);
                    seen_rise = 1'b1;
                end
                if (q_bits.size() == 0) chk("bits_available", 0, 1);
                else begin
                    exp_b = q_bits.pop_front();
                    chk("shift_rgb", int'({pr, pg, pb}), int'(exp_b));
                end
                edges++;
            end
            if (plat) begin
                chk("rises_per_shift", edges, 64);
                edges = 0;
                if (lat_cyc < 0) chk("first_latch_cycle", cyc, 129);
                else             chk("plane_period", cyc - lat_cyc, 130 + cur_w);
                if (nlat % 8 == 0) begin
                    if (line_cyc >= 0) chk("scanline_period", cyc - line_cyc, line_len);
                    line_cyc = cyc;
                end
                lat_cyc = cyc;
                nlat++;
                if (q_a.size() == 0 || q_w.size() == 0) chk("plane_available", 0, 1);
                else begin
                    cur_scan = q_a.pop_front();
                    cur_w    = q_w.pop_front();
                end
                chk("row_is_scan_minus_1", int'(row), (cur_scan + 7) % 8);
                chk("col_holds_63", int'(col), 63);
            end
            if (!poe) begin
                low++;
                if (low == 1) chk("panel_a_while_lit", int'(pa), cur_scan);
            end else if (!poe_q) begin
                chk("oe_low_width", low, cur_w);
                low = 0;
            end
            if (display != disp_q || swap_done) begin
                if (q_sw.size() == 0) chk("unexpected_swap", cyc, -1);
                else                  chk("swap_cycle", cyc, q_sw.pop_front());
                chk("swap_toggle_with_done", int'({swap_done, display ^ disp_q}), 3);
            end
            pclk_q = pclk; poe_q = poe; pa_q = pa; disp_q = display;
        end
    end

    logic       pclk1_q, poe1_q;
    logic [2:0] pa1_q;
    int         lat1, nlat1;

    always @(negedge clk) begin
        if (rst1) begin
            pclk1_q = 1'b0; poe1_q = 1'b1; pa1_q = 3'd0; lat1 = -1; nlat1 = 0;
        end else begin
            inv("dut1", d1_oe, d1_lat, d1_pclk, pclk1_q, d1_pa, pa1_q);
            if (d1_lat) begin
                if (lat1 >= 0) chk("dut1_plane_period", cyc1 - lat1, 130 + (B1 << ((nlat1 - 1) % 8)));
                lat1 = cyc1;
                nlat1++;
            end
            pclk1_q = d1_pclk; poe1_q = d1_oe; pa1_q = d1_pa;
        end
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: run exceeded its cycle budget at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [8:0] ii;
        for (int i = 0; i < 512; i++) begin
            ii = 9'(i);
            mem[i] = 24'($urandom);
            if (ii[7:5] == 3'd0) mem[i][23:16] = {2'b00, ~ii[8], ii[4:0]};
        end
        for (int p = 0; p < 8; p++) line_len += 130 + (B4 << p);
        frame_len = 8 * line_len;
        push_planes(200);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rst1  = 1'b0;

        pulse_swap(100, 1'b1);
        pulse_swap(20000, 1'b1);
        pulse_swap(30000, 1'b1);
        pulse_swap(2 * frame_len - 1, 1'b1);
        pulse_swap(3 * frame_len + 30, 1'b0);

        while (cyc < 3 * frame_len + 50) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_oe_n", int'(poe), 1);
        chk("rst_panel_clk", int'(pclk), 0);
        chk("rst_panel_lat", int'(plat), 0);
        chk("rst_col", int'(col), 0);
        chk("rst_row", int'(row), 7);
        chk("rst_panel_a", int'(pa), 0);
        chk("rst_display", int'(display), 0);
        chk("rst_swap_done", int'(swap_done), 0);
        q_bits.delete();
        q_a.delete();
        q_w.delete();
        push_planes(70);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        while (cyc < frame_len + 200) @(negedge clk);
        chk("latches_after_restart", nlat, 65);
        chk("swaps_outstanding", q_sw.size(), 0);
        chk("dut1_two_frames_seen", int'(nlat1 >= 128), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
